// File: rtl/mat_switch_arbiter.sv
// mat_switch_arbiter: pairs each sending matrix core with the receiver that named it
// and moves one SWITCH_WIDTH-element vector per cycle over a single shared bus.
// Several matched pairs share that bus through a round-robin pointer on the sender index.
// Vector elements travel as raw 32-bit IEEE-754 single-precision bit patterns.
// A bit pattern of all zeros is 0.0.
// Optional feature: define MAT_SWITCH_STATS_EN to add the xfer_count and stall_count outputs.
module mat_switch_arbiter #(
  parameter int SWITCH_WIDTH          = 16,
  parameter int SWITCH_CORE_SIZE      = 4,
  parameter int SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE)
) (
  input  logic                                                    clock,
  input  logic                                                    reset,
  input  logic [SWITCH_CORE_SIZE-1:0]                             send_ready,
  input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0]  send_core_idx,
  input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][31:0]     send_data,
  output logic [SWITCH_CORE_SIZE-1:0]                             send_ok,
  input  logic [SWITCH_CORE_SIZE-1:0]                             recv_request,
  input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0]  recv_core_idx,
  output logic [SWITCH_CORE_SIZE-1:0]                             recv_ready,
  output logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][31:0]     recv_data,
  output logic                                                    busy
`ifdef MAT_SWITCH_STATS_EN
  ,
  output logic [31:0]                                             xfer_count,
  output logic [31:0]                                             stall_count
`endif
);

  typedef logic [SWITCH_CORE_ADDR_SIZE-1:0] core_idx_t;

  logic [SWITCH_CORE_SIZE-1:0] matched;
  logic [SWITCH_CORE_SIZE-1:0] masked;
  logic [SWITCH_CORE_SIZE-1:0] eligible;
  core_idx_t                   dest [SWITCH_CORE_SIZE];
  core_idx_t                   rr_ptr;
  core_idx_t                   rr_next;
  core_idx_t                   cand;
  core_idx_t                   grant_s;
  core_idx_t                   grant_r;
  logic                        grant_valid;

  // Find, for every sender, the receiver that both names it and is named by it.
  // The search only runs over real core numbers, so an out-of-range index can never match.
  always_comb begin
    matched = '0;
    for (int s = 0; s < SWITCH_CORE_SIZE; s++) begin
      dest[s] = '0;
    end
    for (int s = 0; s < SWITCH_CORE_SIZE; s++) begin
      for (int r = 0; r < SWITCH_CORE_SIZE; r++) begin
        if (send_ready[s] && recv_request[r] &&
            int'(send_core_idx[s]) == r && int'(recv_core_idx[r]) == s) begin
          matched[s] = 1'b1;
          dest[s]    = core_idx_t'(r);
        end
      end
    end
  end

  // Cores still seeing their pulse have not had a chance to drop the request yet.
  assign masked = send_ok | recv_ready;

  // A matched pair may compete only while neither of its two cores is mid-pulse.
  always_comb begin
    eligible = '0;
    for (int s = 0; s < SWITCH_CORE_SIZE; s++) begin
      eligible[s] = matched[s] && !masked[s] && !masked[dest[s]];
    end
  end

  // Round-robin search for the first eligible sender at or after rr_ptr.
  // The search wraps modulo the core count.
  always_comb begin
    grant_valid = 1'b0;
    grant_s     = '0;
    grant_r     = '0;
    cand        = '0;
    for (int k = 0; k < SWITCH_CORE_SIZE; k++) begin
      cand = core_idx_t'((int'(rr_ptr) + k) % SWITCH_CORE_SIZE);
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_s     = cand;
        grant_r     = dest[cand];
      end
    end
  end

  // The pointer moves just past the winning sender.
  // That sender then has the lowest priority on the next search.
  assign rr_next = (int'(grant_s) == SWITCH_CORE_SIZE - 1) ? '0 : grant_s + core_idx_t'(1);

  // Register the grant as one-cycle pulses and latch the winning vector into its receiver.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      send_ok    <= '0;
      recv_ready <= '0;
      busy       <= 1'b0;
      recv_data  <= '0;
      rr_ptr     <= '0;
    end else begin
      send_ok    <= '0;
      recv_ready <= '0;
      busy       <= grant_valid;
      if (grant_valid) begin
        send_ok[grant_s]    <= 1'b1;
        recv_ready[grant_r] <= 1'b1;
        recv_data[grant_r]  <= send_data[grant_s];
        rr_ptr              <= rr_next;
      end
    end
  end

`ifdef MAT_SWITCH_STATS_EN
  logic [SWITCH_CORE_SIZE-1:0] grant_vec;
  logic                        stall_any;

  // One-hot view of the winning sender.
  // Used to spot matched pairs that lost this edge.
  always_comb begin
    grant_vec = '0;
    if (grant_valid) begin
      grant_vec[grant_s] = 1'b1;
    end
  end

  assign stall_any = |(matched & ~grant_vec);

  // Saturating counters of completed grants and of edges that left a matched pair waiting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      xfer_count  <= '0;
      stall_count <= '0;
    end else begin
      if (grant_valid && xfer_count != '1) begin
        xfer_count <= xfer_count + 32'd1;
      end
      if (stall_any && stall_count != '1) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mat_switch_arbiter.sv
// tb_mat_switch_arbiter: directed, table-driven bench for mat_switch_arbiter.
// Inputs change on the falling edge and outputs are sampled on the falling edge.
// Build with MAT_SWITCH_STATS_EN defined to also check the transfer and stall counters.
module tb_mat_switch_arbiter;

  localparam int W = 16;
  localparam int N = 4;
  localparam int A = 2;

  logic                      clock;
  logic                      reset;
  logic [N-1:0]              send_ready;
  logic [N-1:0][A-1:0]       send_core_idx;
  logic [N-1:0][W-1:0][31:0] send_data;
  logic [N-1:0]              send_ok;
  logic [N-1:0]              recv_request;
  logic [N-1:0][A-1:0]       recv_core_idx;
  logic [N-1:0]              recv_ready;
  logic [N-1:0][W-1:0][31:0] recv_data;
  logic                      busy;
`ifdef MAT_SWITCH_STATS_EN
  logic [31:0]               xfer_count;
  logic [31:0]               stall_count;
`endif

  logic [N-1:0][W-1:0][31:0] exp_rdata;
  int checks;
  int failures;

  mat_switch_arbiter #(
    .SWITCH_WIDTH(W),
    .SWITCH_CORE_SIZE(N),
    .SWITCH_CORE_ADDR_SIZE(A)
  ) dut (
    .clock(clock),
    .reset(reset),
    .send_ready(send_ready),
    .send_core_idx(send_core_idx),
    .send_data(send_data),
    .send_ok(send_ok),
    .recv_request(recv_request),
    .recv_core_idx(recv_core_idx),
    .recv_ready(recv_ready),
    .recv_data(recv_data),
    .busy(busy)
`ifdef MAT_SWITCH_STATS_EN
    ,
    .xfer_count(xfer_count),
    .stall_count(stall_count)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    string      name;
    logic [3:0] sr;
    logic [7:0] sidx;
    logic [3:0] rq;
    logic [7:0] ridx;
    logic [3:0] eok;
    logic [3:0] erdy;
  } vec_t;

  vec_t vecs [8];

  // Single-precision bit pattern of a small non-negative integer.
  function automatic logic [31:0] float_bits(int unsigned v);
    int unsigned e;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    e = 0;
    while ((v >> (e + 1)) != 0) e++;
    m = (v - (32'd1 << e)) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  // Vector element i of sender s for a given stimulus tag.
  // Tag 0 means core 1 sends the values 0..15 and all other cores send zeros.
  function automatic logic [31:0] word(int tag, int s, int i);
    if (tag == 0) return (s == 1) ? float_bits(i) : 32'h0;
    return float_bits(tag * 64 + s * 16 + i + 1);
  endfunction

  task automatic apply_stimulus(input logic [3:0] sr, input logic [7:0] sidx,
                                input logic [3:0] rq, input logic [7:0] ridx, input int tag);
    send_ready    = sr;
    send_core_idx = sidx;
    recv_request  = rq;
    recv_core_idx = ridx;
    for (int s = 0; s < N; s++)
      for (int i = 0; i < W; i++)
        send_data[s][i] = word(tag, s, i);
  endtask

  task automatic go_idle();
    send_ready   = '0;
    recv_request = '0;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_pulses(input string name, input logic [3:0] eok, input logic [3:0] erdy);
    check_output({name, " send_ok"}, 32'(send_ok), 32'(eok));
    check_output({name, " recv_ready"}, 32'(recv_ready), 32'(erdy));
    check_output({name, " busy"}, 32'(busy), 32'(|eok));
  endtask

  task automatic note_grant(input int tag, input int s, input int r);
    for (int i = 0; i < W; i++) exp_rdata[r][i] = word(tag, s, i);
  endtask

  task automatic check_all_data(input string name);
    for (int r = 0; r < N; r++) begin
      checks++;
      if (recv_data[r] !== exp_rdata[r]) begin
        failures++;
        for (int i = W - 1; i >= 0; i--)
          if (recv_data[r][i] !== exp_rdata[r][i])
            $display("[TB] FAIL %s recv_data[%0d][%0d] actual=%h required=%h",
                     name, r, i, recv_data[r][i], exp_rdata[r][i]);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    exp_rdata = '0;
  endtask

  initial begin
    logic [3:0] seen;
    int gs;
    int gr;
    checks    = 0;
    failures  = 0;
    exp_rdata = '0;
    reset     = 1'b1;
    send_data = '0;
    send_core_idx = '0;
    recv_core_idx = '0;
    go_idle();

    vecs[0] = '{"self 0->0",      4'b0001, 8'h00, 4'b0001, 8'h00, 4'b0001, 4'b0001};
    vecs[1] = '{"3->1",           4'b1000, 8'h40, 4'b0010, 8'h0C, 4'b1000, 4'b0010};
    vecs[2] = '{"no match 0->3",  4'b0001, 8'h03, 4'b1000, 8'h40, 4'b0000, 4'b0000};
    vecs[3] = '{"no receiver",    4'b0100, 8'h00, 4'b0000, 8'h00, 4'b0000, 4'b0000};
    vecs[4] = '{"wrong source",   4'b0100, 8'h00, 4'b0010, 8'h08, 4'b0000, 4'b0000};
    vecs[5] = '{"rr0 1->2,3->0",  4'b1010, 8'h08, 4'b0101, 8'h13, 4'b0010, 4'b0100};
    vecs[6] = '{"rr2 1->2,3->0",  4'b1010, 8'h08, 4'b0101, 8'h13, 4'b1000, 4'b0001};
    vecs[7] = '{"ring rr0",       4'b1111, 8'h39, 4'b1111, 8'h93, 4'b0001, 4'b0010};

    @(negedge clock);
    check_pulses("reset", 4'b0000, 4'b0000);
    check_all_data("reset");
`ifdef MAT_SWITCH_STATS_EN
    check_output("reset xfer_count", xfer_count, 32'd0);
    check_output("reset stall_count", stall_count, 32'd0);
`endif
    reset = 1'b0;

    // Single pair 1->2 carrying 0..15.
    apply_stimulus(4'b0010, 8'h08, 4'b0100, 8'h10, 0);
    step();
    check_pulses("single", 4'b0010, 4'b0100);
    note_grant(0, 1, 2);
    check_all_data("single");
    go_idle();
    step();
    check_pulses("single after", 4'b0000, 4'b0000);
    check_all_data("single hold");

    // Mismatch held for 50 cycles.
    apply_stimulus(4'b0001, 8'h03, 4'b1000, 8'h40, 9);
    seen = '0;
    for (int c = 0; c < 50; c++) begin
      step();
      seen |= send_ok | recv_ready | {3'b000, busy};
    end
    check_output("mismatch pulses", 32'(seen), 32'd0);
    go_idle();
    step();

    // Table of single-edge vectors, each followed by an idle cycle.
    for (int v = 0; v < 8; v++) begin
      apply_stimulus(vecs[v].sr, vecs[v].sidx, vecs[v].rq, vecs[v].ridx, v + 1);
      step();
      check_pulses(vecs[v].name, vecs[v].eok, vecs[v].erdy);
      gs = -1;
      gr = -1;
      for (int k = 0; k < N; k++) begin
        if (vecs[v].eok[k]) gs = k;
        if (vecs[v].erdy[k]) gr = k;
      end
      if (gs >= 0 && gr >= 0) note_grant(v + 1, gs, gr);
      check_all_data(vecs[v].name);
      go_idle();
      step();
      check_pulses({vecs[v].name, " idle"}, 4'b0000, 4'b0000);
    end

    // Contention 0->1 and 2->3 from rr_ptr=0, then re-presented with the pointer at 3.
    do_reset();
    check_all_data("reset 2");
    apply_stimulus(4'b0101, 8'h31, 4'b1010, 8'h80, 20);
    step();
    check_pulses("contend first", 4'b0001, 4'b0010);
    note_grant(20, 0, 1);
    apply_stimulus(4'b0100, 8'h31, 4'b1000, 8'h80, 20);
    step();
    check_pulses("contend second", 4'b0100, 4'b1000);
    note_grant(20, 2, 3);
    check_all_data("contend");
`ifdef MAT_SWITCH_STATS_EN
    check_output("stats xfer_count", xfer_count, 32'd2);
    check_output("stats stall_count", stall_count, 32'd1);
`endif
    go_idle();
    step();
    apply_stimulus(4'b0101, 8'h31, 4'b1010, 8'h80, 21);
    step();
    check_pulses("wrap first", 4'b0001, 4'b0010);
    apply_stimulus(4'b0100, 8'h31, 4'b1000, 8'h80, 21);
    step();
    check_pulses("wrap second", 4'b0100, 4'b1000);
    go_idle();
    step();

    // Bidirectional 0<->1: the reverse direction waits out the masked cycle.
    do_reset();
    apply_stimulus(4'b0011, 8'h01, 4'b0011, 8'h01, 22);
    step();
    check_pulses("bidir first", 4'b0001, 4'b0010);
    apply_stimulus(4'b0010, 8'h01, 4'b0001, 8'h01, 22);
    step();
    check_pulses("bidir gap", 4'b0000, 4'b0000);
    step();
    check_pulses("bidir second", 4'b0010, 4'b0001);
    go_idle();
    step();

    // Reset during the 1->2 pulse, with an extra 3->0 pair that would win under the old pointer.
    apply_stimulus(4'b0010, 8'h08, 4'b0100, 8'h10, 0);
    step();
    check_pulses("pre-reset pulse", 4'b0010, 4'b0100);
    apply_stimulus(4'b1010, 8'h08, 4'b0101, 8'h13, 0);
    #1 reset = 1'b1;
    #1;
    check_pulses("async reset", 4'b0000, 4'b0000);
    exp_rdata = '0;
    check_all_data("async reset");
    #1 reset = 1'b0;
    step();
    check_pulses("after reset", 4'b0010, 4'b0100);
    note_grant(0, 1, 2);
    check_all_data("after reset");
    go_idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mat_switch_arbiter.md
# mat_switch_arbiter

Inter-core switch arbiter that connects the `switch_send_*` / `switch_recv_*` ports of `SWITCH_CORE_SIZE` matrix cores. It pairs each sender with the receiver that named it and moves one `SWITCH_WIDTH`-element vector per cycle over a single shared crossbar bus. Matched pairs share that bus through a round-robin pointer. It sits at the multi-core top level, between the cores' control units.

## Interface
- `SWITCH_WIDTH`, 16: elements per transferred vector.
- `SWITCH_CORE_SIZE`, 4: number of attached cores, ≥2.
- `SWITCH_CORE_ADDR_SIZE`, `$clog2(SWITCH_CORE_SIZE)`: core index width.
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `send_ready`  in  [SWITCH_CORE_SIZE]  core c holds a vector for sending.
- `send_core_idx`  in  [SWITCH_CORE_SIZE][SWITCH_CORE_ADDR_SIZE]  destination core per sender.
- `send_data`  in  [SWITCH_CORE_SIZE] × shortreal[SWITCH_WIDTH]  vector per sender.
- `send_ok`  out  [SWITCH_CORE_SIZE]  one-cycle pulse: sender c's vector was taken.
- `recv_request`  in  [SWITCH_CORE_SIZE]  core c wants a vector.
- `recv_core_idx`  in  [SWITCH_CORE_SIZE][SWITCH_CORE_ADDR_SIZE]  source core per receiver.
- `recv_ready`  out  [SWITCH_CORE_SIZE]  one-cycle pulse: `recv_data[c]` is valid.
- `recv_data`  out  [SWITCH_CORE_SIZE] × shortreal[SWITCH_WIDTH]  delivered vector per receiver.
- `busy`  out  1  high while any `send_ok` bit is pulsing.

## Operation
- **Match rule.** Pair (s→r) is matched when all of these hold: `send_ready[s]`, `send_core_idx[s]==r`, `recv_request[r]`, `recv_core_idx[r]==s`.
  - Self-transfer (s==r) is legal.
  - An index ≥ `SWITCH_CORE_SIZE` never matches.
- **Uniqueness.** Each core has one destination and one source, so at most one pair per sender and at most one per receiver. Contention exists only for the single bus.
- **Mask.** Core x is masked if `send_ok[x]` or `recv_ready[x]` is currently high. A pair is eligible when it is matched and neither s nor r is masked. This prevents re-granting a request the core has not yet dropped.
- **Arbitration.** Grant goes to the eligible pair whose sender index is first at or after `rr_ptr`, searching modulo `SWITCH_CORE_SIZE`.
- **On grant.**
  - `rr_ptr` ← (s+1) mod `SWITCH_CORE_SIZE`.
  - Otherwise `rr_ptr` holds.
- **Transfer.** Next cycle: `send_ok[s]`=1, `recv_ready[r]`=1, `recv_data[r]` ← `send_data[s]` as sampled at the grant edge.
  - All other `send_ok` / `recv_ready` bits are 0.
  - `recv_data` of non-granted receivers holds its last value.
- **Core obligations.** Hold `send_ready` / `send_data` / `recv_request` stable until `ok` / `ready`. Drop them or change them in the pulse cycle.
- **Unmatched requests** wait indefinitely. No timeout, no error.

## Timing
- **Reset values.** All `send_ok`, `recv_ready` and `busy` = 0. `recv_data` = 0.0. `rr_ptr` = 0. Reset takes effect immediately, including mid-pulse.
- **Latency.** Match sampled at edge t → pulses during cycle t..t+1 (one cycle).
- **Throughput.** One transfer per cycle. Disjoint pairs can be granted on back-to-back edges.
- **Bidirectional pair.** When 0→1 and 1→0 are both matched, the second waits one extra cycle because both cores are masked during the first pulse.
- **Request dropped.** A request withdrawn before the grant edge is never granted.
- All outputs are registered. There is no combinational input-to-output path.

## Configuration
- `MAT_SWITCH_STATS_EN` defined: adds two outputs, both reset to 0 and saturating at 2^32−1.
  - `xfer_count` [31:0]: increments on each grant.
  - `stall_count` [31:0]: increments on each edge where ≥1 matched pair is not granted. Pairs that are matched but only masked count too.
- `MAT_SWITCH_STATS_EN` undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
1. **Single pair.** Core1 sends to 2 with `data[i]`=i; core2 requests from 1 → at the next edge `send_ok`=4'b0010 and `recv_ready`=4'b0100 for exactly one cycle, `recv_data[2][i]`=i, `busy`=1 for that cycle.
2. **Mismatch.** Core0 sends to 3; core3 requests from 1; core1 idle → no pulses for 50 cycles, outputs stay 0.
3. **Contention and round-robin.** Pairs 2→3 and 0→1 both matched at edge t with `rr_ptr`=0 → 0→1 pulses after t, 2→3 pulses after t+1, then `rr_ptr`=3. Re-present both → 0→1 first again, since the search wraps from 3 and reaches 0 before 2.
4. **Bidirectional.** 0→1 and 1→0 matched together at `rr_ptr`=0 → 0→1 pulses after edge t, 1→0 pulses after edge t+2, and no pulse is issued after edge t+1.
5. **Reset mid-pulse.** Assert `reset` during the pulse of scenario 1 → `send_ok`, `recv_ready` and `busy` go to 0 asynchronously, `recv_data` = 0.0. After release, held requests are granted with `rr_ptr`=0.
6. **Stats (`MAT_SWITCH_STATS_EN` defined).** Run scenario 3 → `xfer_count`=2, `stall_count`=1.
